// File: rtl/risc_toy_ifetch.sv
// Instruction-fetch unit: fetch PC, granted request to instruction memory,
// DEPTH-entry prefetch FIFO of {instruction, PC} and a redirect/flush port.
module risc_toy_ifetch #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  output logic                   IREQ,
  output logic [AW-1:0]          IADDR,
  input  logic                   IGNT,
  input  logic [DW-1:0]          INSTR,
  input  logic                   REDIR,
  input  logic [AW+1:0]          REDIR_PC,
  output logic                   IF_VALID,
  input  logic                   IF_READY,
  output logic [DW-1:0]          IF_INSTR,
  output logic [AW+1:0]          IF_PC,
  output logic [$clog2(DEPTH):0] IF_LEVEL
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [AW+1:0] RESET_BYTE = (AW+2)'(RESET_PC);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic          run;

  logic [DW-1:0] fifo_instr [DEPTH];
  logic [AW-1:0] fifo_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  logic          pop;
  logic          accept;
  logic          wr_en;
  logic [PW+1:0] committed;

  // Credit check counts the in-flight response and frees the slot popped this cycle.
  assign IF_VALID  = (count != '0) & ~REDIR;
  assign pop       = IF_VALID & IF_READY;
  assign committed = {1'b0, count} + (PW+2)'(inflight) - (PW+2)'(pop);
  assign IREQ      = run & ~REDIR & (committed < (PW+2)'(DEPTH));
  assign accept    = IREQ & IGNT;
  assign wr_en     = inflight & ~REDIR;

  assign IADDR    = fetch_pc;
  assign IF_INSTR = fifo_instr[rd_ptr];
  assign IF_PC    = {fifo_pc[rd_ptr], 2'b00};
  assign IF_LEVEL = count;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_BYTE[AW+1:2];
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      run      <= 1'b1;
      inflight <= accept;
      if (accept) inflight_pc <= fetch_pc;
      // Redirect flushes the queue and drops the response arriving this cycle.
      if (REDIR) begin
        fetch_pc <= REDIR_PC[AW+1:2];
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + AW'(1);
        if (wr_en) begin
          fifo_instr[wr_ptr] <= INSTR;
          fifo_pc[wr_ptr]    <= inflight_pc;
          wr_ptr             <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + (PW+1)'(wr_en) - (PW+1)'(pop);
      end
    end
  end

endmodule

// File: tb/tb_risc_toy_ifetch.sv
// Self-checking bench: queue-based fetch model for the default instance plus a
// sequence check on a small AW=4 instance that exercises address wrap.
module tb_risc_toy_ifetch;

  logic        CLK;
  logic        RSTN;
  logic        IREQ;
  logic [29:0] IADDR;
  logic        IGNT;
  logic [31:0] INSTR;
  logic        REDIR;
  logic [31:0] REDIR_PC;
  logic        IF_VALID;
  logic        IF_READY;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;
  logic [2:0]  IF_LEVEL;

  logic        ireq_w;
  logic [3:0]  iaddr_w;
  logic [31:0] instr_w;
  logic        if_valid_w;
  logic [31:0] if_instr_w;
  logic [5:0]  if_pc_w;
  logic [2:0]  if_level_w;
  logic        one_w;
  logic        zero_w;
  logic [5:0]  redir_pc_w;

  risc_toy_ifetch dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT),
    .INSTR(INSTR), .REDIR(REDIR), .REDIR_PC(REDIR_PC), .IF_VALID(IF_VALID),
    .IF_READY(IF_READY), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC), .IF_LEVEL(IF_LEVEL)
  );

  risc_toy_ifetch #(.AW(4), .RESET_PC(32'h3C)) dut_wrap (
    .CLK(CLK), .RSTN(RSTN), .IREQ(ireq_w), .IADDR(iaddr_w), .IGNT(one_w),
    .INSTR(instr_w), .REDIR(zero_w), .REDIR_PC(redir_pc_w), .IF_VALID(if_valid_w),
    .IF_READY(one_w), .IF_INSTR(if_instr_w), .IF_PC(if_pc_w), .IF_LEVEL(if_level_w)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [29:0] m_fetch;
  logic        m_pend;
  logic [29:0] m_pend_pc;
  logic        m_run;
  logic        exp_pop;
  logic        exp_ireq;
  logic        exp_valid;

  logic        resp_valid, cap_acc;
  logic [29:0] resp_addr, cap_addr;
  logic        w_resp_valid, w_cap_acc, w_cap_pop;
  logic [3:0]  w_resp_addr, w_cap_addr;
  logic [3:0]  w_fetch;
  logic [3:0]  w_out;

  int n_cmp;
  int n_fail;

  function automatic logic [31:0] memfn(input logic [29:0] a);
    return {2'b00, a} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] wmemfn(input logic [3:0] a);
    return 32'h5A5A_0000 | {28'd0, a};
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    q.delete();
    m_fetch      = 30'd0;
    m_pend       = 1'b0;
    m_pend_pc    = 30'd0;
    m_run        = 1'b0;
    resp_valid   = 1'b0;
    w_resp_valid = 1'b0;
    w_fetch      = 4'hF;
    w_out        = 4'hF;
  endtask

  // Model outputs follow from queue occupancy, pending response and run state.
  task automatic checkOutput();
    int occ;
    exp_valid = (q.size() != 0) && !REDIR;
    exp_pop   = exp_valid && IF_READY;
    occ       = q.size() + int'(m_pend) - int'(exp_pop);
    exp_ireq  = m_run && !REDIR && (occ < 4);
    compare("ireq", IREQ, exp_ireq);
    compare("iaddr", IADDR, m_fetch);
    compare("if_valid", IF_VALID, exp_valid);
    compare("if_level", IF_LEVEL, q.size());
    if (exp_valid) begin
      compare("if_pc", IF_PC, q[0].pc);
      compare("if_instr", IF_INSTR, q[0].instr);
    end
    if (RSTN) begin
      if (ireq_w) compare("wrap_iaddr", iaddr_w, w_fetch);
      if (if_valid_w) begin
        compare("wrap_if_pc", if_pc_w, {w_out, 2'b00});
        compare("wrap_if_instr", if_instr_w, wmemfn(w_out));
      end
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic redir, input logic [31:0] rpc,
                               input logic ignt, input logic rdy);
    @(negedge CLK);
    RSTN     = rstn;
    REDIR    = redir;
    REDIR_PC = rpc;
    IGNT     = ignt;
    IF_READY = rdy;
    INSTR    = resp_valid ? memfn(resp_addr) : $urandom();
    instr_w  = w_resp_valid ? wmemfn(w_resp_addr) : $urandom();
    if (!rstn) resetModel();
    #1;
    checkOutput();
  endtask

  task automatic advanceEdge();
    cap_acc    = IREQ & IGNT;
    cap_addr   = IADDR;
    w_cap_acc  = ireq_w;
    w_cap_addr = iaddr_w;
    w_cap_pop  = if_valid_w;
    @(posedge CLK);
    if (!RSTN) begin
      resetModel();
    end else begin
      if (REDIR) begin
        q.delete();
        m_fetch = REDIR_PC[31:2];
        m_pend  = 1'b0;
      end else begin
        if (exp_pop) void'(q.pop_front());
        if (m_pend) q.push_back('{pc: {m_pend_pc, 2'b00}, instr: memfn(m_pend_pc)});
        if (exp_ireq && IGNT) begin
          m_pend    = 1'b1;
          m_pend_pc = m_fetch;
          m_fetch   = m_fetch + 30'd1;
        end else begin
          m_pend = 1'b0;
        end
      end
      m_run        = 1'b1;
      resp_valid   = cap_acc;
      resp_addr    = cap_addr;
      w_resp_valid = w_cap_acc;
      w_resp_addr  = w_cap_addr;
      if (w_cap_acc) w_fetch = w_fetch + 4'd1;
      if (w_cap_pop) w_out = w_out + 4'd1;
    end
  endtask

  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic ignt, input logic rdy);
    applyStimulus(1'b1, redir, rpc, ignt, rdy);
    advanceEdge();
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic pulseReset();
    #2;
    RSTN = 1'b0;
    resetModel();
    #1;
    checkOutput();
    compare("arst_ireq", IREQ, 1'b0);
    compare("arst_iaddr", IADDR, 30'd0);
    compare("arst_if_pc", IF_PC, 32'd0);
    compare("arst_if_instr", IF_INSTR, 32'd0);
    compare("arst_wrap_iaddr", iaddr_w, 4'hF);
    advanceEdge();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    RSTN = 1'b0; REDIR = 1'b0; REDIR_PC = '0; IGNT = 1'b0; IF_READY = 1'b0;
    INSTR = '0; instr_w = '0;
    one_w = 1'b1; zero_w = 1'b0; redir_pc_w = '0;
    resetModel();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      compare("rst_if_pc", IF_PC, 32'd0);
      compare("rst_if_instr", IF_INSTR, 32'd0);
      compare("rst_wrap_iaddr", iaddr_w, 4'hF);
      advanceEdge();
    end

    // Streaming from reset, one instruction per cycle.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("a_ireq_first_cycle", IREQ, 1'b0);
    advanceEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("a_ireq", IREQ, 1'b1);
    compare("a_iaddr0", IADDR, 30'd0);
    compare("a_wrap_ireq", ireq_w, 1'b1);
    compare("a_wrap_iaddr_f", iaddr_w, 4'hF);
    advanceEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("a_iaddr1", IADDR, 30'd1);
    compare("a_valid_early", IF_VALID, 1'b0);
    compare("a_wrap_iaddr_0", iaddr_w, 4'h0);
    advanceEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("a_valid", IF_VALID, 1'b1);
    compare("a_if_pc0", IF_PC, 32'd0);
    compare("a_if_instr0", IF_INSTR, 32'hC0DE_0000);
    compare("a_wrap_if_pc_3c", if_pc_w, 6'h3C);
    advanceEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("a_if_pc4", IF_PC, 32'd4);
    compare("a_wrap_if_pc_00", if_pc_w, 6'h00);
    advanceEdge();
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1);

    // Fill with decode stalled, then drain in order.
    cycle(1'b1, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    compare("b_level_full", IF_LEVEL, 3'd4);
    compare("b_ireq_full", IREQ, 1'b0);
    advanceEdge();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      compare("b_drain_pc", IF_PC, 32'(4 * k));
      if (k == 0) compare("b_ireq_resume", IREQ, 1'b1);
      advanceEdge();
    end

    // Redirect with three buffered entries and one response in flight.
    cycle(1'b1, 32'h200, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h103, 1'b1, 1'b0);
    compare("c_level_before", IF_LEVEL, 3'd3);
    compare("c_valid_redir", IF_VALID, 1'b0);
    compare("c_ireq_redir", IREQ, 1'b0);
    advanceEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("c_level_flushed", IF_LEVEL, 3'd0);
    compare("c_iaddr_target", IADDR, 30'h40);
    compare("c_ireq_after", IREQ, 1'b1);
    advanceEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("c_valid_r2", IF_VALID, 1'b0);
    advanceEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("c_valid_r3", IF_VALID, 1'b1);
    compare("c_if_pc_target", IF_PC, 32'h100);
    advanceEdge();

    // Grant stalls hold the request address.
    cycle(1'b1, 32'h400, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, (k == 0 || k == 3), 1'b1);
      compare("d_iaddr_hold", IADDR, (k == 0) ? 30'h100 : 30'h101);
      advanceEdge();
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1);

    // Asynchronous reset with two entries buffered, then restart.
    cycle(1'b1, 32'h800, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    compare("f_level_two", IF_LEVEL, 3'd2);
    pulseReset();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    advanceEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("f_ireq_first", IREQ, 1'b0);
    advanceEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    compare("f_restart_iaddr", IADDR, 30'd0);
    compare("f_restart_ireq", IREQ, 1'b1);
    advanceEdge();

    // Randomized traffic with one mid-stream reset.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus((i < 1001 || i > 1002), ($urandom_range(15) == 0), $urandom(),
                    ($urandom_range(3) != 0), ($urandom_range(9) < 7));
      if (i == 1000) pulseReset();
      else advanceEdge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
